// File: rtl/demux_sipo_pkg.sv
// demux_sipo_pkg: shared state type and width helper for the serial receiver
package demux_sipo_pkg;
  typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/demux_sipo_rx_if.sv
// demux_sipo_rx_if: serial input and word-level ready/valid bundle
interface demux_sipo_rx_if #(parameter int WIDTH = 8);
  localparam int CNT_W = demux_sipo_pkg::cnt_w(WIDTH);
  logic sin;
  logic sin_valid;
  logic sin_start;
  logic [WIDTH-1:0] dout;
  logic dout_valid;
  logic dout_ready;
  logic busy;
  logic [CNT_W-1:0] bit_cnt;
  logic overrun;
  logic frame_err;
  modport master (
    output sin, sin_valid, sin_start, dout_ready,
    input dout, dout_valid, busy, bit_cnt, overrun, frame_err
  );
  modport slave (
    input sin, sin_valid, sin_start, dout_ready,
    output dout, dout_valid, busy, bit_cnt, overrun, frame_err
  );
endinterface

// File: rtl/demux_1_n.sv
// demux_1_n: 1-to-N decoder producing one-hot slot write enables
module demux_1_n #(
  parameter int N = 8
) (
  input  logic [$clog2(N)-1:0] sel,
  input  logic                 en,
  output logic [N-1:0]         onehot
);
  assign onehot = en ? (N'(1) << sel) : '0;
endmodule

// File: rtl/demux_sipo_rx.sv
// demux_sipo_rx: serial-to-parallel receiver with a one-word ready/valid holding register
module demux_sipo_rx
  import demux_sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic            clk,
  input logic            rst,
  demux_sipo_rx_if.slave rx
);
  localparam int CNT_W = cnt_w(WIDTH);
  localparam int SW    = $clog2(WIDTH);
  rx_state_t r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [WIDTH-1:0] r_sh, w_sh, r_dout, w_dout, w_oh;
  logic r_dv, w_dv, r_ovr, w_ovr, r_ferr, w_ferr;
  logic w_start, w_bit, w_done, w_load;
  logic [SW-1:0] w_pos, w_sel;
  assign w_start = rx.sin_valid & rx.sin_start;
  assign w_bit   = rx.sin_valid & ~rx.sin_start & (r_state == RX_SHIFT);
  assign w_pos   = w_start ? '0 : r_cnt[SW-1:0];
  assign w_sel   = MSB_FIRST ? SW'(WIDTH - 1) - w_pos : w_pos;
  demux_1_n #(.N(WIDTH)) u_demux (.sel(w_sel), .en(w_start | w_bit), .onehot(w_oh));
  // completing bit is merged into w_sh so the load sees the whole word
  always_comb begin
    w_sh    = (w_oh & {WIDTH{rx.sin}}) | (r_sh & ~w_oh);
    w_done  = w_bit && (r_cnt == CNT_W'(WIDTH - 1));
    w_load  = w_done && (!r_dv || rx.dout_ready);
    w_state = w_start ? RX_SHIFT : w_done ? RX_IDLE : r_state;
    w_cnt   = w_start ? CNT_W'(1) : w_done ? '0 : w_bit ? r_cnt + CNT_W'(1) : r_cnt;
    w_dout  = w_load ? w_sh : r_dout;
    w_dv    = w_load ? 1'b1 : (r_dv && rx.dout_ready) ? 1'b0 : r_dv;
    w_ovr   = w_done && !w_load;
    w_ferr  = w_start && (r_state == RX_SHIFT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_dout  <= '0;
      r_dv    <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_sh    <= w_sh;
      r_dout  <= w_dout;
      r_dv    <= w_dv;
      r_ovr   <= w_ovr;
      r_ferr  <= w_ferr;
    end
  end
  assign rx.dout       = r_dout;
  assign rx.dout_valid = r_dv;
  assign rx.busy       = (r_state == RX_SHIFT);
  assign rx.bit_cnt    = r_cnt;
  assign rx.overrun    = r_ovr;
  assign rx.frame_err  = r_ferr;
endmodule

// File: tb/tb_demux_sipo_rx.sv
// tb_demux_sipo_rx: directed and random checks of LSB-first and MSB-first receivers
module tb_demux_sipo_rx;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);
  logic clk = 1'b0, rst = 1'b1;
  logic sin = 1'b0, sin_valid = 1'b0, sin_start = 1'b0, dout_ready = 1'b0;
  int n_chk = 0, n_pass = 0;
  bit q[$];
  logic [W-1:0] m_dl = '0, m_dm = '0;
  logic m_dv = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;

  demux_sipo_rx_if #(.WIDTH(W)) if_l ();
  demux_sipo_rx_if #(.WIDTH(W)) if_m ();
  assign if_l.sin = sin;
  assign if_l.sin_valid = sin_valid;
  assign if_l.sin_start = sin_start;
  assign if_l.dout_ready = dout_ready;
  assign if_m.sin = sin;
  assign if_m.sin_valid = sin_valid;
  assign if_m.sin_start = sin_start;
  assign if_m.dout_ready = dout_ready;

  demux_sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_l (.clk(clk), .rst(rst), .rx(if_l.slave));
  demux_sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_m (.clk(clk), .rst(rst), .rx(if_m.slave));

  always #5 clk = ~clk;

  // model: queue of bits in the current frame; word built from bit positions
  task automatic tick(input logic b, input logic v, input logic s, input logic r);
    logic ld;
    ld = 1'b0;
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    if (v && s) begin
      m_ferr = (q.size() != 0);
      q.delete();
      q.push_back(b);
    end else if (v && q.size() != 0) begin
      q.push_back(b);
      if (q.size() == W) begin
        if (!m_dv || r) begin
          ld = 1'b1;
          m_dl = '0;
          m_dm = '0;
          foreach (q[i]) begin
            m_dl[i] = q[i];
            m_dm[W-1-i] = q[i];
          end
        end else m_ovr = 1'b1;
        q.delete();
      end
    end
    m_dv = ld ? 1'b1 : (m_dv && r) ? 1'b0 : m_dv;
    sin = b; sin_valid = v; sin_start = s; dout_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; sin_start = 1'b0; dout_ready = 1'b0;
    q.delete();
    m_dl = '0; m_dm = '0; m_dv = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic r_body, input logic r_last);
    for (int i = 0; i < W; i++) tick(w[i], 1'b1, i == 0, (i == W - 1) ? r_last : r_body);
  endtask

  task automatic test_reset();
    do_reset(2);
    n_chk++;
    if ({if_l.dout, if_l.dout_valid, if_l.busy, if_l.bit_cnt, if_l.overrun, if_l.frame_err} !== '0)
      $display("FAIL reset_l: got %h/%b/%b/%0d/%b/%b exp all zero", if_l.dout, if_l.dout_valid, if_l.busy, if_l.bit_cnt, if_l.overrun, if_l.frame_err);
    else n_pass++;
    n_chk++;
    if ({if_m.dout, if_m.dout_valid, if_m.busy, if_m.bit_cnt, if_m.overrun, if_m.frame_err} !== '0)
      $display("FAIL reset_m: got %h/%b/%b/%0d/%b/%b exp all zero", if_m.dout, if_m.dout_valid, if_m.busy, if_m.bit_cnt, if_m.overrun, if_m.frame_err);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    n_chk++;
    if (if_l.busy !== 1'b0) $display("FAIL idle_ignore: busy got %b exp 0", if_l.busy); else n_pass++;
    send_word(8'hA5, 1'b0, 1'b0);
    n_chk++;
    if ({if_l.dout, if_l.dout_valid, if_l.busy} !== {8'hA5, 1'b1, 1'b0})
      $display("FAIL basic_word: got %h/%b/%b exp a5/1/0", if_l.dout, if_l.dout_valid, if_l.busy);
    else n_pass++;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    n_chk++;
    if (if_l.dout_valid !== 1'b0) $display("FAIL basic_consume: dout_valid got %b exp 0", if_l.dout_valid); else n_pass++;
  endtask

  task automatic test_gaps();
    logic [W-1:0] w;
    int bad;
    w = 8'hA5;
    bad = 0;
    for (int i = 0; i < W; i++) begin
      tick(w[i], 1'b1, i == 0, 1'b0);
      for (int g = 0; g < 3 && i < W - 1; g++) begin
        if (if_m.bit_cnt !== CW'(i + 1)) bad++;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
      end
      if (i < W - 1 && if_m.bit_cnt !== CW'(i + 1)) bad++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL gap_bitcnt: got %0d wrong samples exp 0", bad); else n_pass++;
    n_chk++;
    if ({if_m.dout, if_m.dout_valid, if_m.bit_cnt} !== {8'hA5, 1'b1, CW'(0)})
      $display("FAIL gap_msb_word: got %h/%b/%0d exp a5/1/0", if_m.dout, if_m.dout_valid, if_m.bit_cnt);
    else n_pass++;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_restart();
    logic [W-1:0] w;
    int ferr_n;
    w = 8'h3C;
    ferr_n = 0;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, i == 0, 1'b0);
    for (int i = 0; i < W; i++) begin
      tick(w[i], 1'b1, i == 0, 1'b0);
      if (if_l.frame_err === 1'b1) ferr_n++;
      if (i == 0) begin
        n_chk++;
        if ({if_l.frame_err, if_l.bit_cnt} !== {1'b1, CW'(1)})
          $display("FAIL restart_pulse: got ferr=%b cnt=%0d exp 1/1", if_l.frame_err, if_l.bit_cnt);
        else n_pass++;
      end
    end
    n_chk++;
    if (ferr_n != 1) $display("FAIL restart_once: got %0d pulses exp 1", ferr_n); else n_pass++;
    n_chk++;
    if ({if_l.dout, if_l.dout_valid, if_l.overrun} !== {8'h3C, 1'b1, 1'b0})
      $display("FAIL restart_word: got %h/%b/%b exp 3c/1/0", if_l.dout, if_l.dout_valid, if_l.overrun);
    else n_pass++;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_overrun();
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    n_chk++;
    if ({if_l.overrun, if_l.dout, if_l.dout_valid} !== {1'b1, 8'h11, 1'b1})
      $display("FAIL overrun_edge: got %b/%h/%b exp 1/11/1", if_l.overrun, if_l.dout, if_l.dout_valid);
    else n_pass++;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    n_chk++;
    if ({if_l.overrun, if_l.dout_valid} !== 2'b00)
      $display("FAIL overrun_consume: got ovr=%b dv=%b exp 0/0", if_l.overrun, if_l.dout_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    send_word(8'h55, 1'b0, 1'b0);
    n_chk++;
    if (if_l.dout !== 8'h55) $display("FAIL b2b_first: got %h exp 55", if_l.dout); else n_pass++;
    send_word(8'hAA, 1'b0, 1'b1);
    n_chk++;
    if ({if_l.dout, if_l.dout_valid, if_l.overrun} !== {8'hAA, 1'b1, 1'b0})
      $display("FAIL b2b_simul: got %h/%b/%b exp aa/1/0", if_l.dout, if_l.dout_valid, if_l.overrun);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, i == 0, 1'b0);
    do_reset(1);
    n_chk++;
    if ({if_l.dout, if_l.dout_valid, if_l.busy, if_l.bit_cnt, if_l.overrun, if_l.frame_err} !== '0)
      $display("FAIL rstmid_zero: got %h/%b/%b/%0d/%b/%b exp all zero", if_l.dout, if_l.dout_valid, if_l.busy, if_l.bit_cnt, if_l.overrun, if_l.frame_err);
    else n_pass++;
    rst = 1'b0;
    send_word(8'hF0, 1'b0, 1'b0);
    n_chk++;
    if ({if_l.dout, if_m.dout, if_l.dout_valid} !== {8'hF0, 8'h0F, 1'b1})
      $display("FAIL rstmid_fresh: got l=%h m=%h dv=%b exp f0/0f/1", if_l.dout, if_m.dout, if_l.dout_valid);
    else n_pass++;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      tick(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0);
      n_chk++;
      if ({if_l.dout, if_l.dout_valid, if_l.busy, if_l.bit_cnt, if_l.overrun, if_l.frame_err} !==
          {m_dl, m_dv, q.size() != 0, CW'(q.size()), m_ovr, m_ferr})
        $display("FAIL rand_l c%0d: got %h/%b/%b/%0d/%b/%b exp %h/%b/%b/%0d/%b/%b", c,
                 if_l.dout, if_l.dout_valid, if_l.busy, if_l.bit_cnt, if_l.overrun, if_l.frame_err,
                 m_dl, m_dv, q.size() != 0, q.size(), m_ovr, m_ferr);
      else n_pass++;
      n_chk++;
      if ({if_m.dout, if_m.dout_valid, if_m.bit_cnt, if_m.overrun, if_m.frame_err} !==
          {m_dm, m_dv, CW'(q.size()), m_ovr, m_ferr})
        $display("FAIL rand_m c%0d: got %h/%b/%0d/%b/%b exp %h/%b/%0d/%b/%b", c,
                 if_m.dout, if_m.dout_valid, if_m.bit_cnt, if_m.overrun, if_m.frame_err,
                 m_dm, m_dv, q.size(), m_ovr, m_ferr);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_restart();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
